// File: rtl/cory_tpram.sv
// rtl/cory_tpram.sv - two-port RAM endpoint for the queue SRAM ports with periodic ready stalls.
// Optional write-first forwarding on same-address collisions: CORY_TPRAM_BYPASS_EN.
module cory_tpram #(
  parameter int N  = 8,
  parameter int Q  = 256,
  parameter int A  = $clog2(Q),
  parameter int WS = 0,
  parameter int RS = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_s_wen,
  input  logic [A-1:0] i_s_waddr,
  input  logic [N-1:0] i_s_wdata,
  output logic         o_s_wready,
  input  logic         i_s_ren,
  input  logic         i_s_oen,
  input  logic [A-1:0] i_s_raddr,
  output logic [N-1:0] o_s_rdata,
  output logic         o_s_rready
);

  localparam int WCW = (WS > 1) ? $clog2(WS) : 1;
  localparam int RCW = (RS > 1) ? $clog2(RS) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'((WS > 0) ? WS - 1 : 0);
  localparam logic [RCW-1:0] RLAST = RCW'((RS > 0) ? RS - 1 : 0);

  logic [N-1:0]   mem [Q];
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic [N-1:0]   rdata_q, rdata_d;
  logic [N-1:0]   oe_q, oe_d;
  logic           w_acc, r_acc;

  // Readies depend only on the counters, never on the request inputs.
  assign o_s_wready = (WS == 0) || (wcnt_q != WLAST);
  assign o_s_rready = (RS == 0) || (rcnt_q != RLAST);

  assign w_acc = !reset && !i_s_wen && o_s_wready;
  assign r_acc = !reset && !i_s_ren && o_s_rready;

  assign o_s_rdata = i_s_oen ? oe_q : rdata_q;

  always_comb begin
    wcnt_d  = (WS == 0 || wcnt_q == WLAST) ? '0 : wcnt_q + WCW'(1);
    rcnt_d  = (RS == 0 || rcnt_q == RLAST) ? '0 : rcnt_q + RCW'(1);
    oe_d    = i_s_oen ? oe_q : rdata_q;
    rdata_d = rdata_q;
    if (r_acc) begin
      rdata_d = mem[i_s_raddr];
`ifdef CORY_TPRAM_BYPASS_EN
      if (w_acc && (i_s_waddr == i_s_raddr)) begin
        rdata_d = i_s_wdata;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      rdata_q <= '0;
      oe_q    <= '0;
    end else begin
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      rdata_q <= rdata_d;
      oe_q    <= oe_d;
    end
  end

  // Storage has no reset so its contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      mem[i_s_waddr] <= i_s_wdata;
    end
  end

`ifdef SIM
  initial begin
    if (WS == 1 || RS == 1) begin
      $display("ERROR: cory_tpram stall period of 1 is illegal (WS=%0d RS=%0d)", WS, RS);
      $finish;
    end
  end

  always @(posedge clk) begin
    if ((w_acc && 32'(i_s_waddr) >= Q) || (r_acc && 32'(i_s_raddr) >= Q)) begin
      $display("ERROR: cory_tpram access beyond depth %0d", Q);
      $finish;
    end
  end
`endif

endmodule

// File: tb/tb_cory_tpram.sv
// tb/tb_cory_tpram.sv - randomized and directed bench for cory_tpram against a reference model.
module tb_cory_tpram;
  localparam int N = 8;
  localparam int Q = 256;
  localparam int A = 8;
  localparam int WSV [2] = '{0, 4};
  localparam int RSV [2] = '{0, 3};
`ifdef CORY_TPRAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, wen, ren, oen;
  logic [A-1:0] waddr, raddr;
  logic [N-1:0] wdata;
  logic [N-1:0] rdata0, rdata1;
  logic         wr0, rr0, wr1, rr1;

  cory_tpram #(.N(N), .Q(Q), .A(A), .WS(0), .RS(0)) u_dut0 (
    .clk(clk), .reset(reset), .i_s_wen(wen), .i_s_waddr(waddr), .i_s_wdata(wdata),
    .o_s_wready(wr0), .i_s_ren(ren), .i_s_oen(oen), .i_s_raddr(raddr),
    .o_s_rdata(rdata0), .o_s_rready(rr0));

  cory_tpram #(.N(N), .Q(Q), .A(A), .WS(4), .RS(3)) u_dut1 (
    .clk(clk), .reset(reset), .i_s_wen(wen), .i_s_waddr(waddr), .i_s_wdata(wdata),
    .o_s_wready(wr1), .i_s_ren(ren), .i_s_oen(oen), .i_s_raddr(raddr),
    .o_s_rdata(rdata1), .o_s_rready(rr1));

  int errors = 0;
  int checks = 0;

  // Reference model: word array, cycles since reset, latest read result, last visible value.
  logic [N-1:0] m_mem  [2][Q];
  logic [N-1:0] m_rd   [2];
  logic [N-1:0] m_seen [2];
  int           cyc = 0;
  bit           m_live = 1'b0;

  bit           x_rd_on = 1'b0;
  logic [N-1:0] x_rd;
  bit           x_st_on = 1'b0;
  bit           x_w, x_r;

  function automatic bit rdy(int per, int c);
    return (per == 0) || ((c % per) != per - 1);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [N-1:0] got [2];
    bit           gw [2];
    bit           gr [2];
    @(negedge clk);
    got[0] = rdata0; got[1] = rdata1;
    gw[0] = wr0; gw[1] = wr1; gr[0] = rr0; gr[1] = rr1;
    if (m_live) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("wready%0d", d), 32'(gw[d]), 32'(rdy(WSV[d], cyc)));
        chk($sformatf("rready%0d", d), 32'(gr[d]), 32'(rdy(RSV[d], cyc)));
        chk($sformatf("rdata%0d", d), 32'(got[d]), 32'(oen ? m_seen[d] : m_rd[d]));
      end
    end
    if (x_rd_on) chk("directed_rdata", 32'(rdata0), 32'(x_rd));
    if (x_st_on) begin
      chk("stall_wready", 32'(wr1), 32'(x_w));
      chk("stall_rready", 32'(rr1), 32'(x_r));
    end
    x_rd_on = 1'b0;
    x_st_on = 1'b0;
    @(posedge clk);
    if (reset) begin
      cyc = 0;
      m_live = 1'b1;
      for (int d = 0; d < 2; d++) begin
        m_rd[d] = '0;
        m_seen[d] = '0;
      end
    end else if (m_live) begin
      for (int d = 0; d < 2; d++) begin
        bit wa, ra;
        wa = !wen && rdy(WSV[d], cyc);
        ra = !ren && rdy(RSV[d], cyc);
        if (!oen) m_seen[d] = m_rd[d];
        if (ra) m_rd[d] = (BYP && wa && waddr == raddr) ? wdata : m_mem[d][raddr];
        if (wa) m_mem[d][waddr] = wdata;
      end
      cyc++;
    end
    #1;
  endtask

  task automatic expect_rd(logic [N-1:0] v);
    x_rd_on = 1'b1;
    x_rd = v;
  endtask

  initial begin
    reset = 1'b1; wen = 1'b1; ren = 1'b1; oen = 1'b1;
    waddr = '0; raddr = '0; wdata = '0;
    tick(); tick();
    reset = 1'b0;

    // Stall pattern straight after reset, idle inputs.
    for (int i = 0; i < 12; i++) begin
      x_st_on = 1'b1;
      x_w = (i % 4) != 3;
      x_r = (i % 3) != 2;
      tick();
    end

    // Preload; each write held two cycles so the stalled instance also commits.
    for (int i = 0; i < 16; i++) begin
      wen = 1'b0; waddr = A'(i); wdata = N'($urandom);
      tick(); tick();
    end
    wen = 1'b0; waddr = 8'd20; wdata = 8'hC3;
    tick(); tick();
    wen = 1'b1;

    // Basic write then read.
    waddr = 8'd3; wdata = 8'hA5; wen = 1'b0;
    tick();
    wen = 1'b1; ren = 1'b0; raddr = 8'd3; oen = 1'b0;
    tick();
    ren = 1'b1; expect_rd(8'hA5);
    tick();

    // Same-address collision.
    wen = 1'b0; waddr = 8'd7; wdata = 8'h11;
    tick();
    wdata = 8'h22; ren = 1'b0; raddr = 8'd7;
    tick();
    wen = 1'b1; expect_rd(BYP ? 8'h22 : 8'h11);
    tick();
    ren = 1'b1; expect_rd(8'h22);
    tick();

    // Output hold while oen is high.
    wen = 1'b0; waddr = 8'd5; wdata = 8'h5A;
    tick();
    waddr = 8'd6; wdata = 8'h3C;
    tick();
    wen = 1'b1; ren = 1'b0; raddr = 8'd5; oen = 1'b1;
    tick();
    ren = 1'b1; oen = 1'b0; expect_rd(8'h5A);
    tick();
    ren = 1'b0; raddr = 8'd6; oen = 1'b1; expect_rd(8'h5A);
    tick();
    ren = 1'b1; expect_rd(8'h5A);
    tick();
    oen = 1'b0; expect_rd(8'h3C);
    tick();

    // Random traffic over a small address window, with one mid-run reset.
    for (int i = 0; i < 400; i++) begin
      wen   = ($urandom % 2) == 0;
      ren   = ($urandom % 2) == 0;
      oen   = ($urandom % 4) == 0;
      waddr = A'($urandom % 16);
      raddr = A'($urandom % 16);
      wdata = N'($urandom);
      reset = (i == 200);
      if (i == 201) begin
        expect_rd('0);
        x_st_on = 1'b1; x_w = 1'b1; x_r = 1'b1;
      end
      tick();
    end
    reset = 1'b0;

    // Contents written before the reset survive it.
    wen = 1'b1; ren = 1'b0; raddr = 8'd20; oen = 1'b0;
    tick();
    ren = 1'b1; expect_rd(8'hC3);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
